wptr_full_sync: RTL and testbench
=================================

// Module: wptr_full_sync
// PURPOSE
//  Write-domain pointer and full-flag generator for the dual-clock async FIFO.
//  Sits directly upstream of the FIFO memory and drives its waddr and wfull inputs.
//  Resynchronises the read-domain Gray pointer into wclk with 2 flops.
//  Keeps the binary and Gray write pointers, and produces a registered full flag,
//  a fill level and a sticky overflow flag.
// PARAMETERS
//  ADDRSIZE      6   memory address bits; DEPTH = 1<<ADDRSIZE (64)
//  AFULL_THRESH  60  walmost_full threshold in words; valid range 1..DEPTH
// PORTS
//  wclk          in   1           write clock; all state updates on posedge
//  wrst          in   1           reset; asynchronous, active-high
//  winc          in   1           write request from producer
//  rptr          in   ADDRSIZE+1  read-domain Gray pointer (async to wclk)
//  waddr         out  ADDRSIZE    memory write address = wbin[ADDRSIZE-1:0]
//  wptr          out  ADDRSIZE+1  registered Gray write pointer, to read-domain sync
//  wfull         out  1           FIFO full; writes are ignored while high
//  wlevel        out  ADDRSIZE+1  registered fill level, 0..DEPTH (pessimistic)
//  woverflow     out  1           sticky: a winc arrived while wfull was high
//  walmost_full  out  1           wlevel >= AFULL_THRESH (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, wrst=1): every register cleared.
//    - Cleared: wbin, wptr, wq1_rptr, wq2_rptr, wfull, wlevel, woverflow, walmost_full.
//    - So waddr=0 and all outputs are 0 while wrst is high.
//    - Reset mid-operation discards all state immediately.
//    - The read side must be reset in the same window.
//  - Sync: wq1_rptr <= rptr; wq2_rptr <= wq1_rptr.
//    - No other logic uses rptr directly.
//  - Accept: push = winc & ~wfull.
//    - wbinnext = wbin + push, mod 2^(ADDRSIZE+1).
//    - wgraynext = (wbinnext>>1) ^ wbinnext.
//    - Each posedge: wbin <= wbinnext; wptr <= wgraynext.
//  - Latency: write accepted in cycle N -> waddr/wptr advance at the edge ending cycle N.
//    - The memory samples the old waddr on that same edge.
//  - Full: wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A=ADDRSIZE.
//    - wfull rises on the same edge that accepts the DEPTH-th outstanding word.
//    - No extra cycle of latency.
//  - Full release: after rptr changes, wfull deasserts at the 3rd wclk edge.
//    - 2 edges for the sync, 1 for the register.
//    - This latency is conservative by design; no write is lost.
//  - Level: wlevel <= wbinnext - gray2bin(wq2_rptr), mod 2^(A+1).
//    - Always 0..DEPTH; wlevel==DEPTH iff wfull.
//    - Overstates the true level by up to 3 cycles of reads.
//  - Overflow: woverflow <= woverflow | (winc & wfull).
//    - Cleared only by reset.
//    - The rejected write does not move the pointers.
//  - Wrap: wbin wraps from 2^(A+1)-1 to 0 and the Gray code wraps with it.
//    - The MSB toggle distinguishes full from empty.
//    - No special case at waddr DEPTH-1 -> 0.
//  - Simultaneous events:
//    - Same edge that a read frees a slot while a write is pending at wfull=1: write rejected.
//      It is accepted once wfull drops.
//    - A write and a synced read on the same edge: wlevel unchanged.
// CONFIGURATION
//  WPTR_ALMOST_FULL_EN defined:
//    - walmost_full <= (wlevel_next >= AFULL_THRESH); wlevel_next is the value being loaded into wlevel.
//    - Registered; reset to 0.
//  WPTR_ALMOST_FULL_EN undefined:
//    - walmost_full tied to 1'b0; no comparator logic.
//    - Port kept so the interface is identical in both builds.
// TESTING
//  1 Reset: wrst=1 mid-stream with wbin=37.
//    -> All outputs 0 immediately, without waiting for a clock edge.
//    -> Holds 0 until release.
//  2 Fill: rptr=0, winc=1 for 64 cycles.
//    -> waddr steps 0..63.
//    -> wfull=1 on the 64th edge; wlevel=64; wptr=7'b1100000.
//  3 Overflow: continue winc=1 at full for 2 cycles.
//    -> waddr stays at 0 and wptr is unchanged.
//    -> woverflow=1 and stays 1 after traffic stops.
//  4 Release: from full, drive rptr=gray(1)=7'b0000001.
//    -> wfull=0 on the 3rd wclk edge; wlevel=63.
//    -> The next winc is accepted.
//  5 Wrap: stream 200 writes with rptr following at 2-cycle lag.
//    -> wbin passes 127->0; wfull never asserts.
//    -> wlevel matches the model every cycle.
//  6 Almost-full: with WPTR_ALMOST_FULL_EN, fill to 59 then 60 words.
//    -> walmost_full 0 then 1.
//    -> Without the macro it stays 0 throughout.

Source files
------------

// File: rtl/wptr_full_sync.sv
// Write-side pointer, full flag, fill level and sticky overflow for the dual-clock async FIFO.
// Optional registered almost-full output is built only when WPTR_ALMOST_FULL_EN is defined.
module wptr_full_sync #(
  parameter int ADDRSIZE     = 6,
  parameter int AFULL_THRESH = 60
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow,
  output logic                walmost_full
);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wq1_rptr;
  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] wq2_rbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] wlevel_next;
  logic              wfull_next;
  logic              push;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign push        = winc & ~wfull;
  assign wbinnext    = wbin + {{ADDRSIZE{1'b0}}, push};
  assign wgraynext   = (wbinnext >> 1) ^ wbinnext;
  assign wq2_rbin    = gray2bin(wq2_rptr);
  assign wlevel_next = wbinnext - wq2_rbin;
  // Full when the write pointer has lapped the synced read pointer: top two Gray bits inverted.
  assign wfull_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
  assign waddr       = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wq1_rptr  <= '0;
      wq2_rptr  <= '0;
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      wlevel    <= '0;
      woverflow <= 1'b0;
    end else begin
      wq1_rptr  <= rptr;
      wq2_rptr  <= wq1_rptr;
      wbin      <= wbinnext;
      wptr      <= wgraynext;
      wfull     <= wfull_next;
      wlevel    <= wlevel_next;
      woverflow <= woverflow | (winc & wfull);
    end
  end

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE + 1)'(AFULL_THRESH);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (wlevel_next >= AFULL_LVL);
    end
  end
`else
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_sync.sv
// Self-checking bench for wptr_full_sync: vector table, directed corner cases and a
// randomized run compared against a count-based reference model.
module tb_wptr_full_sync;

  localparam int A     = 6;
  localparam int DEPTH = 1 << A;
  localparam int MODP  = 2 * DEPTH;
  localparam int AFT   = 60;

  logic         wclk = 1'b0;
  logic         wrst = 1'b1;
  logic         winc = 1'b0;
  logic [A:0]   rptr = '0;
  logic [A-1:0] waddr;
  logic [A:0]   wptr;
  logic         wfull;
  logic [A:0]   wlevel;
  logic         woverflow;
  logic         walmost_full;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: total words written, read counts seen two and one edges ago
  int m_wr, m_q1, m_q2, m_level;
  bit m_full, m_ovf, m_af;

  wptr_full_sync #(.ADDRSIZE(A), .AFULL_THRESH(AFT)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .wlevel(wlevel),
    .woverflow(woverflow), .walmost_full(walmost_full)
  );

  always #5 wclk = ~wclk;

  function automatic int gray(input int b);
    return (b ^ (b >> 1));
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_wr = 0; m_q1 = 0; m_q2 = 0; m_level = 0;
    m_full = 0; m_ovf = 0; m_af = 0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " waddr"}, int'(waddr), m_wr % DEPTH);
    checkOutput({tag, " wptr"}, int'(wptr), gray(m_wr % MODP));
    checkOutput({tag, " wfull"}, int'(wfull), int'(m_full));
    checkOutput({tag, " wlevel"}, int'(wlevel), m_level);
    checkOutput({tag, " woverflow"}, int'(woverflow), int'(m_ovf));
    checkOutput({tag, " walmost_full"}, int'(walmost_full), int'(m_af));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " waddr"}, int'(waddr), 0);
    checkOutput({tag, " wptr"}, int'(wptr), 0);
    checkOutput({tag, " wfull"}, int'(wfull), 0);
    checkOutput({tag, " wlevel"}, int'(wlevel), 0);
    checkOutput({tag, " woverflow"}, int'(woverflow), 0);
    checkOutput({tag, " walmost_full"}, int'(walmost_full), 0);
  endtask

  // One write-clock cycle: drive on negedge, advance the model at posedge, settle before return
  task automatic applyStimulus(input bit w, input int rd);
    bit old_full;
    @(negedge wclk);
    winc = w;
    rptr = (A+1)'(gray(rd % MODP));
    @(posedge wclk);
    old_full = m_full;
    if (w && !m_full) m_wr++;
    m_level = (m_wr - m_q2) % MODP;
    m_q2    = m_q1;
    m_q1    = rd;
    m_full  = (m_level == DEPTH);
    m_ovf   = m_ovf | (w & old_full);
`ifdef WPTR_ALMOST_FULL_EN
    m_af    = (m_level >= AFT);
`else
    m_af    = 0;
`endif
    #1;
  endtask

  task automatic doReset();
    @(negedge wclk);
    wrst = 1'b1;
    winc = 1'b0;
    rptr = '0;
    @(negedge wclk);
    wrst = 1'b0;
    modelReset();
  endtask

  typedef struct {
    bit winc;
    int rd;
    int exp_waddr;
    int exp_level;
    bit exp_full;
  } vec_t;

  vec_t vecs[7];

  int  rd_cnt, hist1, hist2;
  bit  seen_full;
  bit  saw_wrap;

  initial begin
    vecs[0] = '{1, 0, 1, 1, 0};
    vecs[1] = '{1, 0, 2, 2, 0};
    vecs[2] = '{0, 0, 2, 2, 0};
    vecs[3] = '{1, 0, 3, 3, 0};
    vecs[4] = '{0, 1, 3, 3, 0};
    vecs[5] = '{0, 1, 3, 3, 0};
    vecs[6] = '{0, 1, 3, 2, 0};

    modelReset();
    #2;
    checkAllZero("reset_initial");
    @(negedge wclk);
    wrst = 1'b0;

    // Table: read pointer change takes effect on wlevel at the third edge
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].winc, vecs[i].rd);
      checkOutput($sformatf("vec%0d waddr", i), int'(waddr), vecs[i].exp_waddr);
      checkOutput($sformatf("vec%0d wlevel", i), int'(wlevel), vecs[i].exp_level);
      checkOutput($sformatf("vec%0d wfull", i), int'(wfull), int'(vecs[i].exp_full));
    end

    // Asynchronous reset mid-stream with wbin=37
    doReset();
    for (int i = 0; i < 37; i++) applyStimulus(1, 0);
    checkOutput("pre_reset waddr", int'(waddr), 37);
    #2;
    wrst = 1'b1;
    #1;
    checkAllZero("async_reset");
    winc = 1'b1;
    repeat (2) begin
      @(posedge wclk);
      #1;
      checkAllZero("reset_hold");
    end
    @(negedge wclk);
    winc = 1'b0;
    wrst = 1'b0;
    modelReset();

    // Fill to full with the reader idle
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("fill waddr_before", int'(waddr), i);
      applyStimulus(1, 0);
      checkModel("fill");
    end
    checkOutput("full wfull", int'(wfull), 1);
    checkOutput("full wlevel", int'(wlevel), 64);
    checkOutput("full wptr", int'(wptr), 7'b1100000);

    // Writes at full are rejected and set the sticky overflow
    repeat (2) begin
      applyStimulus(1, 0);
      checkOutput("ovf waddr", int'(waddr), 0);
      checkOutput("ovf wptr", int'(wptr), 7'b1100000);
    end
    checkOutput("ovf flag", int'(woverflow), 1);
    repeat (3) applyStimulus(0, 0);
    checkOutput("ovf sticky", int'(woverflow), 1);

    // Release: one read frees a slot, seen on the third edge
    applyStimulus(0, 1);
    checkOutput("rel edge1 wfull", int'(wfull), 1);
    applyStimulus(0, 1);
    checkOutput("rel edge2 wfull", int'(wfull), 1);
    applyStimulus(0, 1);
    checkOutput("rel edge3 wfull", int'(wfull), 0);
    checkOutput("rel edge3 wlevel", int'(wlevel), 63);
    applyStimulus(1, 1);
    checkOutput("rel accept waddr", int'(waddr), 1);
    checkOutput("rel accept wlevel", int'(wlevel), 64);
    checkOutput("rel accept wfull", int'(wfull), 1);
    checkModel("rel");

    // Wrap: 200 writes with the reader two cycles behind
    doReset();
    hist1 = 0; hist2 = 0; seen_full = 0; saw_wrap = 0;
    for (int i = 0; i < 200; i++) begin
      int rd;
      rd    = hist2;
      hist2 = hist1;
      hist1 = m_wr;
      applyStimulus(1, rd);
      checkModel("wrap");
      if (wfull) seen_full = 1;
      if (m_wr == MODP) saw_wrap = (int'(wptr) == 0);
    end
    checkOutput("wrap never_full", int'(seen_full), 0);
    checkOutput("wrap wptr_at_128", int'(saw_wrap), 1);
    checkOutput("wrap total_written", m_wr, 200);

    // Randomized traffic against the model
    doReset();
    rd_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      bit w;
      w = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && rd_cnt < m_wr) rd_cnt++;
      applyStimulus(w, rd_cnt);
      checkModel("rand");
    end

    // Almost-full threshold
    doReset();
    for (int i = 0; i < 59; i++) applyStimulus(1, 0);
    checkOutput("af 59 wlevel", int'(wlevel), 59);
    checkOutput("af 59 walmost_full", int'(walmost_full), 0);
    applyStimulus(1, 0);
    checkOutput("af 60 wlevel", int'(wlevel), 60);
`ifdef WPTR_ALMOST_FULL_EN
    checkOutput("af 60 walmost_full", int'(walmost_full), 1);
`else
    checkOutput("af 60 walmost_full", int'(walmost_full), 0);
`endif
    applyStimulus(0, 0);
    checkModel("af hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
